mul_share_sched: RTL and testbench

Round-robin scheduler that shares one 4x4 array multiplier between two requesters (e.g. two operand-entry channels feeding the 7-segment display path). It accepts an operand pair from the winning requester and drives it onto the shared multiplier. It then registers the 9-bit product and returns it with a one-cycle done strobe to the owner. All sequencing lives here; the multiplier stays purely combinational.

---
 rtl/mul_sched_pkg.sv | 28 ++
 rtl/mul_share_sched_rr_arb2.sv | 25 ++
 rtl/mul_share_sched.sv | 141 ++++++++++++++
 tb/tb_mul_share_sched.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/mul_sched_pkg.sv
// +-----------------------------------------------------------------------------
// | Module      : mul_sched_pkg
// | Description : Shared types and constants for the multiplier-sharing scheduler.
// | Revision    : 1.0 - initial release
// +-----------------------------------------------------------------------------
`default_nettype none

package mul_sched_pkg;

  localparam int OP_W_DEF = 4;

  // Product is one bit wider than the natural 2*OP_W result.
  function automatic int p_w_of(input int op_w);
    return 2 * op_w + 1;
  endfunction

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  typedef logic owner_t;

endpackage

`default_nettype wire

// File: rtl/mul_share_sched_rr_arb2.sv
// +-----------------------------------------------------------------------------
// | Module      : rr_arb2
// | Description : Combinational 2-way round-robin picker.
// | Revision    : 1.0 - initial release
// +-----------------------------------------------------------------------------
`default_nettype none

module rr_arb2
  import mul_sched_pkg::*;
(
  input  logic [1:0] req,
  input  owner_t     last,
  output logic       win_valid,
  output owner_t     win_id
);

  // On contention the requester that was not served last wins.
  always_comb begin
    win_valid = |req;
    win_id    = (req == 2'b11) ? ~last : req[1];
  end

endmodule

`default_nettype wire

// File: rtl/mul_share_sched.sv
// +-----------------------------------------------------------------------------
// | Module      : mul_share_sched
// | Description : Round-robin scheduler sharing one combinational multiplier
// |               between two requesters. Optional result checker enabled by
// |               macro MUL_SCHED_CHECK_EN.
// | Revision    : 1.0 - initial release
// +-----------------------------------------------------------------------------
`default_nettype none

module mul_share_sched
  import mul_sched_pkg::*;
#(
  parameter  int OP_W = OP_W_DEF,
  localparam int P_W  = 2 * OP_W + 1
) (
  input  logic            clk,
  input  logic            clear,
  input  logic            req0,
  input  logic            req1,
  input  logic [OP_W-1:0] a0,
  input  logic [OP_W-1:0] b0,
  input  logic [OP_W-1:0] a1,
  input  logic [OP_W-1:0] b1,
  output logic            gnt0,
  output logic            gnt1,
  output logic            done0,
  output logic            done1,
  output logic [P_W-1:0]  prod,
  output logic            busy,
  output logic [OP_W-1:0] mul_a,
  output logic [OP_W-1:0] mul_b,
  output logic            mul_clear,
  input  logic [P_W-1:0]  mul_m,
  output logic            mul_err
);

  state_t          state_q, state_d;
  owner_t          owner_q, owner_d;
  owner_t          last_q, last_d;
  logic [OP_W-1:0] op_a_q, op_a_d;
  logic [OP_W-1:0] op_b_q, op_b_d;
  logic [P_W-1:0]  prod_q, prod_d;

  logic            win_valid;
  owner_t          win_id;
  logic            drive;

  rr_arb2 u_arb (
    .req       ({req1, req0}),
    .last      (last_q),
    .win_valid (win_valid),
    .win_id    (win_id)
  );

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      op_a_q  <= '0;
      op_b_q  <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      prod_q  <= prod_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    prod_d  = prod_q;
    case (state_q)
      IDLE: begin
        if (win_valid) begin
          owner_d = win_id;
          op_a_d  = win_id ? a1 : a0;
          op_b_d  = win_id ? b1 : b0;
          state_d = LOAD;
        end
      end
      LOAD:   state_d = SAMPLE;
      SAMPLE: begin
        // Operands have been stable on the multiplier for a full cycle here.
        prod_d  = mul_m;
        last_d  = owner_q;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    drive     = (state_q == LOAD) || (state_q == SAMPLE);
    gnt0      = (state_q == LOAD) && !owner_q;
    gnt1      = (state_q == LOAD) &&  owner_q;
    done0     = (state_q == DONE) && !owner_q;
    done1     = (state_q == DONE) &&  owner_q;
    busy      = (state_q != IDLE);
    mul_a     = drive ? op_a_q : '0;
    mul_b     = drive ? op_b_q : '0;
    mul_clear = drive;
    prod      = prod_q;
  end

`ifdef MUL_SCHED_CHECK_EN
  logic           err_q, err_d;
  logic [P_W-1:0] ref_prod;

  always_comb begin
    ref_prod = P_W'(op_a_q) * P_W'(op_b_q);
    err_d    = err_q;
    if ((state_q == SAMPLE) && (mul_m != ref_prod)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign mul_err = err_q;
`else
  assign mul_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mul_share_sched.sv
// +-----------------------------------------------------------------------------
// | Module      : tb_mul_share_sched
// | Description : Scoreboard bench for mul_share_sched with a behavioural
// |               multiplier model. Honours MUL_SCHED_CHECK_EN.
// | Revision    : 1.0 - initial release
// +-----------------------------------------------------------------------------
`default_nettype none

module tb_mul_share_sched;

  logic       clk;
  logic       clear;
  logic       req0, req1;
  logic [3:0] a0, b0, a1, b1;
  logic       gnt0, gnt1, done0, done1, busy;
  logic [8:0] prod;
  logic [3:0] mul_a, mul_b;
  logic       mul_clear;
  logic [8:0] mul_m;
  logic       mul_err;
  logic       corrupt;

  int errors = 0;
  int checks = 0;
  logic [9:0] exp_q[$];

  mul_share_sched dut (
    .clk       (clk),
    .clear     (clear),
    .req0      (req0),
    .req1      (req1),
    .a0        (a0),
    .b0        (b0),
    .a1        (a1),
    .b1        (b1),
    .gnt0      (gnt0),
    .gnt1      (gnt1),
    .done0     (done0),
    .done1     (done1),
    .prod      (prod),
    .busy      (busy),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_clear (mul_clear),
    .mul_m     (mul_m),
    .mul_err   (mul_err)
  );

  // Shared multiplier model: gated by mul_clear, optionally corrupted.
  assign mul_m = corrupt ? 9'd0 : (mul_clear ? ({5'd0, mul_a} * {5'd0, mul_b}) : 9'd0);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every done pulse.
  always @(negedge clk) begin
    if (!clear) begin
      if (done0 || done1) begin
        chk("done_exclusive", {31'd0, done0 & done1}, 32'd0);
        chk("gnt_done_overlap", {31'd0, gnt0 | gnt1}, 32'd0);
        if (exp_q.size() == 0) begin
          chk("done_unexpected", 32'd1, 32'd0);
        end else begin
          chk("done_owner_prod", {22'd0, done1, prod}, {22'd0, exp_q.pop_front()});
          chk("prod_msb", {31'd0, prod[8]}, 32'd0);
        end
      end
    end
  end

  task automatic wait_gnt(input bit own, output int cyc);
    bit seen;
    seen = 1'b0;
    cyc  = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      cyc++;
      if (own ? gnt1 : gnt0) seen = 1'b1;
    end
    chk("gnt_timeout", {31'd0, seen}, 32'd1);
  endtask

  task automatic do_op(input bit own, input logic [3:0] a, input logic [3:0] b,
                       input logic [8:0] expp);
    int c;
    if (own) begin req1 = 1'b1; a1 = a; b1 = b; end
    else     begin req0 = 1'b1; a0 = a; b0 = b; end
    exp_q.push_back({own, expp});
    wait_gnt(own, c);
    chk("gnt_latency", c, 1);
    if (own) req1 = 1'b0; else req0 = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic reset_pulse();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  initial begin
    int c;
    clear = 1'b1; req0 = 1'b0; req1 = 1'b0; corrupt = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {8'd0, gnt0, gnt1, done0, done1, busy, mul_clear, mul_err,
                          mul_a, mul_b, prod}, 32'd0);
    clear = 1'b0;

    // Single owner-0 transaction, cycle by cycle.
    req0 = 1'b1; a0 = 4'd3; b0 = 4'd5;
    exp_q.push_back({1'b0, 9'd15});
    @(negedge clk);
    chk("c1_gnt0_busy", {30'd0, gnt0, busy}, 32'd3);
    req0 = 1'b0;
    @(negedge clk);
    chk("c2_sample_drive", {21'd0, busy, gnt0, mul_clear, mul_a, mul_b},
        {21'd0, 1'b1, 1'b0, 1'b1, 4'd3, 4'd5});
    @(negedge clk);
    chk("c3_done0_busy", {29'd0, done0, busy, mul_clear}, {29'd0, 3'b110});
    @(negedge clk);
    chk("c4_idle", {21'd0, busy, mul_clear, mul_a, mul_b, done0}, 32'd0);

    // Both held from reset: owner 0 first, then owner 1 four cycles later.
    reset_pulse();
    req0 = 1'b1; a0 = 4'd15; b0 = 4'd15;
    req1 = 1'b1; a1 = 4'd2;  b1 = 4'd7;
    exp_q.push_back({1'b0, 9'd225});
    exp_q.push_back({1'b1, 9'd14});
    wait_gnt(1'b0, c);
    chk("both_first_gnt0", c, 1);
    req0 = 1'b0;
    wait_gnt(1'b1, c);
    chk("both_gnt_spacing", c, 4);
    req1 = 1'b0;
    repeat (3) @(negedge clk);

    // Pointer fairness: after an owner-0 op, simultaneous requests go to owner 1.
    do_op(1'b0, 4'd9, 4'd9, 9'd81);
    req0 = 1'b1; a0 = 4'd1;  b0 = 4'd2;
    req1 = 1'b1; a1 = 4'd10; b1 = 4'd11;
    exp_q.push_back({1'b1, 9'd110});
    exp_q.push_back({1'b0, 9'd2});
    wait_gnt(1'b1, c);
    chk("fair_first_gnt1", c, 1);
    req1 = 1'b0;
    wait_gnt(1'b0, c);
    chk("fair_gnt_spacing", c, 4);
    req0 = 1'b0;
    repeat (3) @(negedge clk);

    // Abort during SAMPLE; held req0 must be re-granted from IDLE.
    req0 = 1'b1; a0 = 4'd6; b0 = 4'd7;
    wait_gnt(1'b0, c);
    @(negedge clk);
    chk("abort_in_sample", {31'd0, mul_clear}, 32'd1);
    clear = 1'b1;
    @(negedge clk);
    chk("abort_outputs", {8'd0, gnt0, gnt1, done0, done1, busy, mul_clear, mul_err,
                          mul_a, mul_b, prod}, {23'd0, 9'd0});
    clear = 1'b0;
    exp_q.push_back({1'b0, 9'd42});
    wait_gnt(1'b0, c);
    chk("abort_regrant", c, 1);
    req0 = 1'b0;
    repeat (3) @(negedge clk);

`ifdef MUL_SCHED_CHECK_EN
    corrupt = 1'b1;
    do_op(1'b0, 4'd4, 4'd4, 9'd0);
    corrupt = 1'b0;
    chk("err_set", {31'd0, mul_err}, 32'd1);
    repeat (3) @(negedge clk);
    chk("err_sticky", {31'd0, mul_err}, 32'd1);
    clear = 1'b1;
    @(negedge clk);
    chk("err_cleared", {31'd0, mul_err}, 32'd0);
    clear = 1'b0;
`else
    do_op(1'b0, 4'd4, 4'd4, 9'd16);
    chk("err_tied_low", {31'd0, mul_err}, 32'd0);
`endif

    // Full operand sweep through requester 1.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        do_op(1'b1, 4'(a), 4'(b), 9'(a * b));
      end
    end

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    chk("final_err_state", {31'd0, mul_err}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
